t1rocket_sim_monitor: RTL and testbench
=======================================

# t1rocket_sim_monitor

Synthesizable simulation-end monitor that consumes the testbench clock and reset and decides when and how a cosim run ends. It counts cycles since reset release, watches instruction commits for a stall timeout, drives the waveform dump window, and reports a single finish event (pass, fail, timeout, or dump-end) to the harness over a valid/ready handshake. It sits beside the DUT top in the emulator and turns per-cycle state into run-level verdicts.

## Interface
- `CYCLE_WIDTH`, default 64: width of the cycle counter and the dump-window bounds.
- `TIMEOUT_WIDTH`, default 32: width of the commit-idle counter and the timeout config.
- `DRAIN_CYCLES`, default 16: cycles to wait after `quit_req` before reporting. 0 is legal.

Ports:
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `cfg_timeout` in TIMEOUT_WIDTH: maximum number of cycles between commits. 0 disables the timeout.
- `cfg_dump_start` in CYCLE_WIDTH: first cycle on which dumping is enabled.
- `cfg_dump_end` in CYCLE_WIDTH: cycle on which the run ends with dump-end status. 0 disables it.
- `commit_valid` in 1: one-cycle pulse per retired instruction.
- `quit_req` in 1: the program requested exit.
- `quit_code` in 8: exit code, valid together with `quit_req`.
- `cycle` out CYCLE_WIDTH: number of cycles since reset release.
- `idle_count` out TIMEOUT_WIDTH: number of cycles since the last commit.
- `dump_enable` out 1: waveform dump window is active.
- `finish_valid` out 1: finish report is pending.
- `finish_ready` in 1: the harness accepts the report.
- `finish_status` out 2: 0 = pass, 1 = fail, 2 = timeout, 3 = dump_end.
- `finish_code` out 8: latched `quit_code`. Reads 0 for timeout and dump_end.
- `state` out 2: 0 = RUN, 1 = DRAIN, 2 = REPORT, 3 = DONE.

## Operation
- **Reset.** Every cycle with `reset` high does the following:
  - All `cfg_*` inputs are captured into registers. Config changes after reset release are ignored.
  - State is forced to RUN.
  - Every output goes to 0: `cycle`, `idle_count`, `dump_enable`, `finish_valid`, `finish_status`, `finish_code`, `state`.
- **cycle.** Increments by 1 every cycle in RUN, DRAIN and REPORT. Frozen in DONE. Wraps modulo 2^CYCLE_WIDTH.
- **idle_count.**
  - Cleared to 0 on any cycle with `commit_valid`.
  - Otherwise increments, saturating at all-ones.
  - Updates in RUN and DRAIN only.
- **RUN exits.** Evaluated on registered values each RUN cycle, in this priority order:
  1. `quit_req`: latch `quit_code`, go to DRAIN with the drain counter loaded to DRAIN_CYCLES. If DRAIN_CYCLES = 0, go directly to REPORT.
  2. `cfg_timeout != 0` and `idle_count == cfg_timeout` and no `commit_valid` this cycle: go to REPORT with status 2.
  3. `cfg_dump_end != 0` and `cycle == cfg_dump_end`: go to REPORT with status 3.
- **DRAIN.**
  - The drain counter decrements each cycle. On the cycle it reads 1, go to REPORT.
  - Status on entry to REPORT is 0 if `finish_code == 0`, otherwise 1.
  - `quit_req`, timeout and dump_end are ignored in DRAIN.
- **REPORT.**
  - `finish_valid` = 1.
  - `finish_status` and `finish_code` are held stable until `finish_ready` is sampled high.
  - On that handshake, go to DONE.
- **DONE.** Terminal until reset. `finish_valid` = 0. All inputs are ignored.
- **dump_enable.** Registered. Next value is 1 iff all of:
  - state is not DONE;
  - `cycle >= cfg_dump_start`;
  - `cfg_dump_end == 0` or `cycle < cfg_dump_end`.
- **Simultaneous events.**
  - `commit_valid` together with the timeout condition: the commit wins, no timeout.
  - `quit_req` together with timeout or dump_end: quit wins.

## Timing
- "Cycle N" means the cycle in which the `cycle` output reads N. The first cycle after reset release is cycle 0.
- `quit_req` sampled at cycle N: DRAIN spans cycles N+1 to N+DRAIN_CYCLES; `finish_valid` rises at cycle N+DRAIN_CYCLES+1.
- Timeout with no commits from reset release: `idle_count` equals `cfg_timeout` at cycle `cfg_timeout`, and `finish_valid` rises one cycle later.
- Dump-end: `finish_valid` rises at cycle `cfg_dump_end + 1`.
- `dump_enable` reflects the `cycle` value of the previous cycle, so it is one cycle of latency behind.
- Handshake completes on the edge where `finish_valid` and `finish_ready` are both high. DONE is visible on the next cycle.
- Reset asserted in any state: all outputs read their reset values on the next cycle. A pending report is dropped.

## Test plan
- Pass exit:
  - stimulus: DRAIN_CYCLES = 16, `quit_req` with code 0 at cycle 100, `finish_ready` held high;
  - required: `finish_valid` at cycle 117, status 0, code 0, DONE at cycle 118, `cycle` frozen at 118.
- Timeout:
  - stimulus: `cfg_timeout` = 5, no commits;
  - required: `idle_count` reads 0 through 5 over cycles 0–5, `finish_valid` at cycle 6 with status 2.
  - Variant: a commit at cycle 5 clears `idle_count` and no finish occurs until cycle 12.
- Dump window:
  - stimulus: `cfg_dump_start` = 10, `cfg_dump_end` = 20;
  - required: `dump_enable` high during cycles 11–20, `finish_valid` at cycle 21 with status 3.
- Priority:
  - stimulus: `quit_req` (code 7) in the same cycle as the timeout condition, DRAIN_CYCLES = 0;
  - required: REPORT on the next cycle, status 1, code 7.
- Backpressure:
  - stimulus: `finish_ready` held low for 10 cycles in REPORT;
  - required: `finish_valid` and status remain stable and `cycle` keeps counting; DONE one cycle after `finish_ready` rises.
- Reset mid-run:
  - stimulus: reset asserted during DRAIN;
  - required: all outputs read 0 on the next cycle, new `cfg_*` values are captured, and the counts restart from cycle 0.

Source files
------------

// File: rtl/t1rocket_sim_monitor_if.sv
// Finish-report handshake between the simulation-end monitor and the harness.
// The monitor drives the report fields; the harness answers with finish_ready.
interface t1rocket_sim_monitor_if;
    logic       finish_valid;
    logic       finish_ready;
    logic [1:0] finish_status;
    logic [7:0] finish_code;

    modport master (
        output finish_valid,
        output finish_status,
        output finish_code,
        input  finish_ready
    );

    modport slave (
        input  finish_valid,
        input  finish_status,
        input  finish_code,
        output finish_ready
    );
endinterface

// File: rtl/t1rocket_sim_monitor.sv
// Simulation-end monitor: counts cycles, watches commits for a stall timeout,
// gates the waveform dump window and reports exactly one finish event per run.
module t1rocket_sim_monitor #(
    parameter int CYCLE_WIDTH   = 64,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int DRAIN_CYCLES  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic [CYCLE_WIDTH-1:0]   cfg_dump_start,
    input  logic [CYCLE_WIDTH-1:0]   cfg_dump_end,
    input  logic                     commit_valid,
    input  logic                     quit_req,
    input  logic [7:0]               quit_code,
    output logic [CYCLE_WIDTH-1:0]   cycle,
    output logic [TIMEOUT_WIDTH-1:0] idle_count,
    output logic                     dump_enable,
    output logic [1:0]               state,
    t1rocket_sim_monitor_if.master   fin_if
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

    // A nonzero program exit code is a failing run.
    function automatic logic [1:0] exit_status(input logic [7:0] code);
        return (code == 8'd0) ? 2'd0 : 2'd1;
    endfunction

    logic [TIMEOUT_WIDTH-1:0] cfg_timeout_q;
    logic [CYCLE_WIDTH-1:0]   cfg_dump_start_q;
    logic [CYCLE_WIDTH-1:0]   cfg_dump_end_q;

    state_e                   state_q, state_d;
    logic [CYCLE_WIDTH-1:0]   cycle_q, cycle_d;
    logic [TIMEOUT_WIDTH-1:0] idle_count_q, idle_count_d;
    logic                     dump_enable_q, dump_enable_d;
    logic [DRAIN_W-1:0]       drain_q, drain_d;
    logic                     finish_valid_q, finish_valid_d;
    logic [1:0]               finish_status_q, finish_status_d;
    logic [7:0]               finish_code_q, finish_code_d;

    logic                     timeout_hit_s;
    logic                     dump_end_hit_s;

    // Next-state, counters and report fields.
    always_comb begin
        state_d         = state_q;
        cycle_d         = cycle_q;
        idle_count_d    = idle_count_q;
        drain_d         = drain_q;
        finish_status_d = finish_status_q;
        finish_code_d   = finish_code_q;

        timeout_hit_s  = (cfg_timeout_q != {TIMEOUT_WIDTH{1'b0}}) &&
                         (idle_count_q == cfg_timeout_q) && !commit_valid;
        dump_end_hit_s = (cfg_dump_end_q != {CYCLE_WIDTH{1'b0}}) &&
                         (cycle_q == cfg_dump_end_q);

        if (state_q != ST_DONE) begin
            cycle_d = cycle_q + CYCLE_WIDTH'(1);
        end else begin
            cycle_d = cycle_q;
        end

        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            if (commit_valid) begin
                idle_count_d = {TIMEOUT_WIDTH{1'b0}};
            end else if (idle_count_q != {TIMEOUT_WIDTH{1'b1}}) begin
                idle_count_d = idle_count_q + TIMEOUT_WIDTH'(1);
            end else begin
                idle_count_d = idle_count_q;
            end
        end else begin
            idle_count_d = idle_count_q;
        end

        case (state_q)
            ST_RUN: begin
                // Quit outranks timeout, which outranks dump-end.
                if (quit_req) begin
                    finish_code_d = quit_code;
                    if (DRAIN_CYCLES == 0) begin
                        state_d         = ST_REPORT;
                        finish_status_d = exit_status(quit_code);
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end else if (timeout_hit_s) begin
                    state_d         = ST_REPORT;
                    finish_status_d = 2'd2;
                    finish_code_d   = 8'd0;
                end else if (dump_end_hit_s) begin
                    state_d         = ST_REPORT;
                    finish_status_d = 2'd3;
                    finish_code_d   = 8'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DRAIN_W'(1);
                if (drain_q == DRAIN_W'(1)) begin
                    state_d         = ST_REPORT;
                    finish_status_d = exit_status(finish_code_q);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_REPORT: begin
                if (fin_if.finish_ready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        finish_valid_d = (state_d == ST_REPORT);
        dump_enable_d  = (state_q != ST_DONE) && (cycle_q >= cfg_dump_start_q) &&
                         ((cfg_dump_end_q == {CYCLE_WIDTH{1'b0}}) ||
                          (cycle_q < cfg_dump_end_q));
    end

    // State and output registers; config is only captured while in reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_timeout_q    <= cfg_timeout;
            cfg_dump_start_q <= cfg_dump_start;
            cfg_dump_end_q   <= cfg_dump_end;
            state_q          <= ST_RUN;
            cycle_q          <= {CYCLE_WIDTH{1'b0}};
            idle_count_q     <= {TIMEOUT_WIDTH{1'b0}};
            dump_enable_q    <= 1'b0;
            drain_q          <= {DRAIN_W{1'b0}};
            finish_valid_q   <= 1'b0;
            finish_status_q  <= 2'd0;
            finish_code_q    <= 8'd0;
        end else begin
            state_q          <= state_d;
            cycle_q          <= cycle_d;
            idle_count_q     <= idle_count_d;
            dump_enable_q    <= dump_enable_d;
            drain_q          <= drain_d;
            finish_valid_q   <= finish_valid_d;
            finish_status_q  <= finish_status_d;
            finish_code_q    <= finish_code_d;
        end
    end

    assign cycle                = cycle_q;
    assign idle_count           = idle_count_q;
    assign dump_enable          = dump_enable_q;
    assign state                = state_q;
    assign fin_if.finish_valid  = finish_valid_q;
    assign fin_if.finish_status = finish_status_q;
    assign fin_if.finish_code   = finish_code_q;

endmodule

// File: tb/tb_t1rocket_sim_monitor.sv
// Bench for t1rocket_sim_monitor: two instances (16-cycle and zero drain) share
// stimulus; a scenario-level model predicts finish cycle, status and code.
module tb_t1rocket_sim_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_timeout = 32'd0;
    logic [63:0] cfg_dump_start = 64'd0;
    logic [63:0] cfg_dump_end = 64'd0;
    logic        commit_valid = 1'b0;
    logic        quit_req = 1'b0;
    logic [7:0]  quit_code = 8'd0;

    logic [63:0] cyc [2];
    logic [31:0] idl [2];
    logic        den [2];
    logic [1:0]  st  [2];
    logic        fv  [2];
    logic        rdy [2];
    logic [1:0]  fst [2];
    logic [7:0]  fcd [2];

    always #5 clock = ~clock;

    t1rocket_sim_monitor_if if16 ();
    t1rocket_sim_monitor_if if0 ();

    assign if16.finish_ready = rdy[0];
    assign if0.finish_ready  = rdy[1];
    assign fv[0]  = if16.finish_valid;
    assign fst[0] = if16.finish_status;
    assign fcd[0] = if16.finish_code;
    assign fv[1]  = if0.finish_valid;
    assign fst[1] = if0.finish_status;
    assign fcd[1] = if0.finish_code;

    t1rocket_sim_monitor #(.DRAIN_CYCLES(16)) dut16 (
        .clock(clock), .reset(reset), .cfg_timeout(cfg_timeout),
        .cfg_dump_start(cfg_dump_start), .cfg_dump_end(cfg_dump_end),
        .commit_valid(commit_valid), .quit_req(quit_req), .quit_code(quit_code),
        .cycle(cyc[0]), .idle_count(idl[0]), .dump_enable(den[0]), .state(st[0]),
        .fin_if(if16)
    );

    t1rocket_sim_monitor #(.DRAIN_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .cfg_timeout(cfg_timeout),
        .cfg_dump_start(cfg_dump_start), .cfg_dump_end(cfg_dump_end),
        .commit_valid(commit_valid), .quit_req(quit_req), .quit_code(quit_code),
        .cycle(cyc[1]), .idle_count(idl[1]), .dump_enable(den[1]), .state(st[1]),
        .fin_if(if0)
    );

    int checks = 0;
    int errors = 0;

    // Scenario description
    int          sc_T;
    longint      sc_S;
    longint      sc_E;
    int          sc_Q;
    logic [7:0]  sc_code;
    bit          cm [0:511];
    int          dly [2];
    int          abort_at;

    // Model predictions and observations
    int          ef [2];
    logic [1:0]  es [2];
    logic [7:0]  ec [2];
    bit          qp [2];
    int          obs_fin [2];
    logic [1:0]  obs_st [2];
    logic [7:0]  obs_cd [2];
    int          obs_done [2];

    localparam int DRAIN_OF [2] = '{16, 0};

    function automatic int idle_at(input int m);
        int last = -1;
        for (int c = 0; c < m; c++) if (cm[c]) last = c;
        return (last < 0) ? m : (m - last - 1);
    endfunction

    task automatic model(input int d);
        ef[d] = -1; es[d] = 2'd0; ec[d] = 8'd0; qp[d] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (n == sc_Q) begin
                ef[d] = n + DRAIN_OF[d] + 1; es[d] = (sc_code != 8'd0) ? 2'd1 : 2'd0;
                ec[d] = sc_code; qp[d] = 1'b1; break;
            end
            if (sc_T != 0 && idle_at(n) == sc_T && !cm[n]) begin
                ef[d] = n + 1; es[d] = 2'd2; break;
            end
            if (sc_E != 0 && longint'(n) == sc_E) begin
                ef[d] = n + 1; es[d] = 2'd3; break;
            end
        end
        if (ef[d] < 0) ef[d] = 400;
    endtask

    task automatic clear_stim();
        sc_T = 0; sc_S = 0; sc_E = 0; sc_Q = -1; sc_code = 8'd0;
        for (int i = 0; i < 512; i++) cm[i] = 1'b0;
        dly[0] = 0; dly[1] = 0; abort_at = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_timeout = 32'(sc_T); cfg_dump_start = 64'(sc_S); cfg_dump_end = 64'(sc_E);
        commit_valid = 1'b0; quit_req = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({cyc[d], idl[d], den[d], st[d], fv[d], fst[d], fcd[d]} !== 110'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got cyc=%0d idle=%0d den=%0b st=%0d fv=%0b fst=%0d fcd=%0d want all 0",
                         d, cyc[d], idl[d], den[d], st[d], fv[d], fst[d], fcd[d]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        // Config changes after release must have no effect.
        cfg_timeout = $urandom_range(1, 3);
        cfg_dump_start = 64'($urandom);
        cfg_dump_end = 64'($urandom_range(1, 4));
    endtask

    task automatic run_scenario();
        int h [2];
        int last;
        for (int d = 0; d < 2; d++) begin
            model(d);
            h[d] = ef[d] + dly[d];
            obs_fin[d] = -1; obs_done[d] = -1; obs_st[d] = 2'd0; obs_cd[d] = 8'd0;
        end
        last = ((h[0] > h[1]) ? h[0] : h[1]) + 3;
        if (abort_at >= 0) last = abort_at;
        do_reset();
        for (int n = 0; n <= last && n < 512; n++) begin
            for (int d = 0; d < 2; d++) begin
                longint e_cyc;
                int     e_idle;
                logic   e_fv;
                logic   e_den;
                logic [1:0] e_st;
                e_cyc  = (n <= h[d]) ? longint'(n) : longint'(h[d] + 1);
                e_idle = idle_at((n < ef[d]) ? n : ef[d]);
                e_fv   = (n >= ef[d]) && (n <= h[d]);
                if (n == 0 || n > h[d] + 1) e_den = 1'b0;
                else e_den = (longint'(n - 1) >= sc_S) && (sc_E == 0 || longint'(n - 1) < sc_E);
                if (n < ef[d]) e_st = (qp[d] && n > sc_Q) ? 2'd1 : 2'd0;
                else if (n <= h[d]) e_st = 2'd2;
                else e_st = 2'd3;

                if (obs_fin[d] < 0 && fv[d] === 1'b1) begin
                    obs_fin[d] = n; obs_st[d] = fst[d]; obs_cd[d] = fcd[d];
                end
                if (obs_done[d] < 0 && st[d] === 2'd3) obs_done[d] = n;

                checks++;
                if (cyc[d] !== 64'(e_cyc)) begin
                    errors++;
                    $display("FAIL cycle dut%0d n=%0d got %0d want %0d", d, n, cyc[d], e_cyc);
                end
                checks++;
                if (idl[d] !== 32'(e_idle)) begin
                    errors++;
                    $display("FAIL idle_count dut%0d n=%0d got %0d want %0d", d, n, idl[d], e_idle);
                end
                checks++;
                if (fv[d] !== e_fv) begin
                    errors++;
                    $display("FAIL finish_valid dut%0d n=%0d got %0b want %0b", d, n, fv[d], e_fv);
                end
                checks++;
                if (den[d] !== e_den) begin
                    errors++;
                    $display("FAIL dump_enable dut%0d n=%0d got %0b want %0b", d, n, den[d], e_den);
                end
                checks++;
                if (st[d] !== e_st) begin
                    errors++;
                    $display("FAIL state dut%0d n=%0d got %0d want %0d", d, n, st[d], e_st);
                end
                if (e_fv) begin
                    checks++;
                    if (fst[d] !== es[d] || fcd[d] !== ec[d]) begin
                        errors++;
                        $display("FAIL report dut%0d n=%0d got status %0d code %0d want status %0d code %0d",
                                 d, n, fst[d], fcd[d], es[d], ec[d]);
                    end
                end
            end
            commit_valid = cm[n];
            quit_req     = (n == sc_Q);
            quit_code    = (n == sc_Q) ? sc_code : 8'($urandom);
            for (int d = 0; d < 2; d++) rdy[d] = (n >= ef[d] + dly[d]);
            @(negedge clock);
        end
        commit_valid = 1'b0;
        quit_req = 1'b0;
    endtask

    task automatic test_pass();
        clear_stim(); sc_Q = 100; sc_code = 8'd0;
        run_scenario();
        checks++;
        if (obs_fin[0] !== 117 || obs_st[0] !== 2'd0 || obs_cd[0] !== 8'd0 || obs_done[0] !== 118) begin
            errors++;
            $display("FAIL pass_exit got fin=%0d st=%0d cd=%0d done=%0d want fin=117 st=0 cd=0 done=118",
                     obs_fin[0], obs_st[0], obs_cd[0], obs_done[0]);
        end
    endtask

    task automatic test_timeout();
        clear_stim(); sc_T = 5;
        run_scenario();
        checks++;
        if (obs_fin[0] !== 6 || obs_fin[1] !== 6 || obs_st[0] !== 2'd2 || obs_cd[1] !== 8'd0) begin
            errors++;
            $display("FAIL timeout got fin=%0d/%0d st=%0d cd=%0d want fin=6/6 st=2 cd=0",
                     obs_fin[0], obs_fin[1], obs_st[0], obs_cd[1]);
        end
        clear_stim(); sc_T = 5; cm[5] = 1'b1;
        run_scenario();
        checks++;
        if (obs_fin[0] !== 12 || obs_st[1] !== 2'd2) begin
            errors++;
            $display("FAIL timeout_commit got fin=%0d st=%0d want fin=12 st=2", obs_fin[0], obs_st[1]);
        end
    endtask

    task automatic test_dump_window();
        clear_stim(); sc_S = 10; sc_E = 20;
        run_scenario();
        checks++;
        if (obs_fin[0] !== 21 || obs_st[0] !== 2'd3) begin
            errors++;
            $display("FAIL dump_end got fin=%0d st=%0d want fin=21 st=3", obs_fin[0], obs_st[0]);
        end
    endtask

    task automatic test_priority();
        clear_stim(); sc_T = 5; sc_Q = 5; sc_code = 8'd7; sc_E = 5;
        run_scenario();
        checks++;
        if (obs_fin[1] !== 6 || obs_st[1] !== 2'd1 || obs_cd[1] !== 8'd7) begin
            errors++;
            $display("FAIL priority got fin=%0d st=%0d cd=%0d want fin=6 st=1 cd=7",
                     obs_fin[1], obs_st[1], obs_cd[1]);
        end
    endtask

    task automatic test_back_pressure();
        clear_stim(); sc_Q = 30; sc_code = 8'd9; dly[0] = 10; dly[1] = 10;
        run_scenario();
        checks++;
        if (obs_fin[0] !== 47 || obs_done[0] !== 58 || obs_done[1] !== 42) begin
            errors++;
            $display("FAIL back_pressure got fin=%0d done=%0d/%0d want fin=47 done=58/42",
                     obs_fin[0], obs_done[0], obs_done[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_stim(); sc_Q = 20; sc_code = 8'd3; sc_T = 9; abort_at = 25;
        run_scenario();
        clear_stim(); sc_S = 4; sc_E = 33;
        run_scenario();
        checks++;
        if (obs_fin[0] !== 34 || obs_st[0] !== 2'd3) begin
            errors++;
            $display("FAIL reset_mid_run got fin=%0d st=%0d want fin=34 st=3", obs_fin[0], obs_st[0]);
        end
    endtask

    task automatic test_random();
        repeat (12) begin
            int dens;
            clear_stim();
            sc_T = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
            sc_S = longint'($urandom_range(0, 100));
            sc_E = ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(30, 200));
            sc_Q = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 150)) : -1;
            if (sc_E == 0 && sc_Q < 0) sc_Q = int'($urandom_range(0, 150));
            sc_code = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(1, 255));
            dens = int'($urandom_range(0, 20));
            for (int i = 0; i < 512; i++) cm[i] = (int'($urandom_range(0, 99)) < dens);
            dly[0] = int'($urandom_range(0, 8));
            dly[1] = int'($urandom_range(0, 8));
            run_scenario();
        end
    endtask

    initial begin
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        clear_stim();
        @(negedge clock);
        test_pass();
        test_timeout();
        test_dump_window();
        test_priority();
        test_back_pressure();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
